// File: rtl/ps2_key_assembler.sv
// ps2_key_assembler
//   Deframes raw PS/2 keyboard serial frames into scancode bytes and groups
//   the bytes into complete key events (prefixes, break codes, PrintScreen,
//   Pause). Each completed event is published on ps2_key.
//
// Ports
//   clk_sys      system clock; all logic runs in this domain
//   RESET        asynchronous, active-high reset
//   ps2_clk_in   raw PS/2 clock line (asynchronous)
//   ps2_data_in  raw PS/2 data line (asynchronous)
//   ps2_key      [64] toggles per completed event, [63:0] event bytes,
//                most recent byte in [7:0], zero-filled above the oldest
//   byte_valid   one-cycle pulse per good received byte
//   byte_data    last good byte, held between pulses
//   frame_err    one-cycle pulse on a parity or stop-bit error
module ps2_key_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [64:0] ps2_key,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  // ------------------------------------------------------------------
  // Input synchronisers and falling-edge detect
  // ------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  // Idle PS/2 lines are high, so the chain resets high to avoid a false edge.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync[0]  <= ps2_clk_in;
      data_sync[0] <= ps2_data_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        clk_sync[i]  <= clk_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
      clk_prev <= clk_s;
    end
  end

  // ------------------------------------------------------------------
  // Deframer: bit 0 start, 1-8 data LSB first, 9 odd parity, 10 stop
  // ------------------------------------------------------------------
  logic [3:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par_bit;
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        case (bit_cnt)
          4'd0: begin
            // A high start bit is line noise: stay idle, no error.
            if (!data_s) bit_cnt <= 4'd1;
          end
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
          4'd9: begin
            par_bit <= data_s;
            bit_cnt <= 4'd10;
          end
          4'd10: begin
            bit_cnt <= '0;
            if (data_s && (^{shreg, par_bit})) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: bit_cnt <= '0;
        endcase
      end else if (bit_cnt != 4'd0) begin
        // Stalled mid-frame: silently drop the partial frame.
        if (tmo_cnt == TMO_LAST) begin
          bit_cnt <= '0;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Event assembler
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    PAUSE
  } asm_state_t;

  asm_state_t  state;
  // Only seven bytes are stored: the eighth byte of the window is always
  // the incoming one, and any event reaching it either completes or
  // drops the oldest byte, so a stored eighth byte is never observed.
  logic [55:0] ev_buf;
  logic [2:0]  ev_cnt;
  logic [63:0] shifted;
  logic        is_prefix;
  logic        is_prtsc_cont;

  always_comb begin
    shifted       = {ev_buf, byte_data};
    is_prefix     = (byte_data == 8'hE0) || (byte_data == 8'hF0);
    is_prtsc_cont = (shifted == 64'h0000_0000_0000_E012) ||
                    (shifted == 64'h0000_0000_00E0_F07C);
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      ev_buf  <= '0;
      ev_cnt  <= '0;
      ps2_key <= '0;
    end else if (frame_err) begin
      state  <= IDLE;
      ev_buf <= '0;
      ev_cnt <= '0;
    end else if (byte_valid) begin
      case (state)
        IDLE: begin
          if (byte_data == 8'hE1) begin
            ev_buf <= {48'h0, byte_data};
            ev_cnt <= 3'd1;
            state  <= PAUSE;
          end else if (is_prefix) begin
            ev_buf <= {48'h0, byte_data};
            state  <= ACCUM;
          end else begin
            ps2_key <= {~ps2_key[64], 56'h0, byte_data};
            ev_buf  <= '0;
            ev_cnt  <= '0;
          end
        end
        ACCUM: begin
          if (is_prefix || is_prtsc_cont) begin
            ev_buf <= shifted[55:0];
          end else begin
            ps2_key <= {~ps2_key[64], shifted};
            ev_buf  <= '0;
            ev_cnt  <= '0;
            state   <= IDLE;
          end
        end
        PAUSE: begin
          if (ev_cnt == 3'd7) begin
            ps2_key <= {~ps2_key[64], shifted};
            ev_buf  <= '0;
            ev_cnt  <= '0;
            state   <= IDLE;
          end else begin
            ev_buf <= shifted[55:0];
            ev_cnt <= ev_cnt + 3'd1;
          end
        end
        default: begin
          ev_buf <= '0;
          ev_cnt <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
